// File: rtl/demux_pkg.sv
// Shared types and helpers for the demux sequencing controller.
package demux_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_W   = 2;

  localparam logic [CH_W-1:0] CH_A = 2'd0;
  localparam logic [CH_W-1:0] CH_B = 2'd1;
  localparam logic [CH_W-1:0] CH_C = 2'd2;
  localparam logic [CH_W-1:0] CH_D = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Channel code to one-hot valid vector.
  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
    logic [NUM_CH-1:0] v;
    v     = '0;
    v[ch] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/demux_wait_timer.sv
// Counts stalled HOLD cycles; expire flags the last permitted cycle.
module demux_wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned WAIT_W = 8;

  logic [WAIT_W-1:0] r_wait_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (clear) begin
      r_wait_cnt <= '0;
    end else if (enable) begin
      r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end
  end

  assign expire = (r_wait_cnt == WAIT_W'(TIMEOUT - 1));

endmodule

// File: rtl/demux_sched.sv
// Accepts one word at a time, steers it to a channel and drops it on stall timeout.
module demux_sched
  import demux_pkg::*;
#(
  parameter int unsigned W       = 1,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [CH_W-1:0]   sel_i,
  input  logic              in_valid,
  input  logic [W-1:0]      in_data,
  output logic              in_ready,
  output logic [W-1:0]      out_data,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [CH_W-1:0]   sel_o,
  output logic              busy,
  output logic              drop_pulse,
  output logic [CNT_W-1:0]  drop_cnt
);

  state_t            r_state,      w_nxt_state;
  logic [W-1:0]      r_hold,       w_nxt_hold;
  logic [CH_W-1:0]   r_sel,        w_nxt_sel;
  logic [NUM_CH-1:0] r_out_valid,  w_nxt_out_valid;
  logic [CH_W-1:0]   r_rr_ptr,     w_nxt_rr_ptr;
  logic              r_rr_mode,    w_nxt_rr_mode;
  logic              r_drop_pulse, w_nxt_drop_pulse;
  logic [CNT_W-1:0]  r_drop_cnt,   w_nxt_drop_cnt;

  logic w_accept;
  logic w_done;
  logic w_ready_tgt;
  logic w_expire;

  assign w_ready_tgt = out_ready[r_sel];

  demux_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (w_accept),
    .enable ((r_state == ST_HOLD) && !w_ready_tgt),
    .expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_hold       <= '0;
      r_sel        <= CH_A;
      r_out_valid  <= '0;
      r_rr_ptr     <= CH_A;
      r_rr_mode    <= 1'b0;
      r_drop_pulse <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_state      <= w_nxt_state;
      r_hold       <= w_nxt_hold;
      r_sel        <= w_nxt_sel;
      r_out_valid  <= w_nxt_out_valid;
      r_rr_ptr     <= w_nxt_rr_ptr;
      r_rr_mode    <= w_nxt_rr_mode;
      r_drop_pulse <= w_nxt_drop_pulse;
      r_drop_cnt   <= w_nxt_drop_cnt;
    end
  end

  // Transfer wins over drop when ready arrives on the last permitted cycle.
  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_hold       = r_hold;
    w_nxt_sel        = r_sel;
    w_nxt_out_valid  = r_out_valid;
    w_nxt_rr_ptr     = r_rr_ptr;
    w_nxt_rr_mode    = r_rr_mode;
    w_nxt_drop_pulse = 1'b0;
    w_nxt_drop_cnt   = r_drop_cnt;
    w_accept         = 1'b0;
    w_done           = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_accept        = 1'b1;
          w_nxt_hold      = in_data;
          w_nxt_sel       = mode ? r_rr_ptr : sel_i;
          w_nxt_out_valid = ch_onehot(w_nxt_sel);
          w_nxt_rr_mode   = mode;
          w_nxt_state     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_ready_tgt) begin
          w_done = 1'b1;
        end else if (w_expire) begin
          w_done           = 1'b1;
          w_nxt_drop_pulse = 1'b1;
          if (r_drop_cnt != {CNT_W{1'b1}}) begin
            w_nxt_drop_cnt = r_drop_cnt + CNT_W'(1);
          end
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase

    if (w_done) begin
      w_nxt_state     = ST_IDLE;
      w_nxt_out_valid = '0;
      if (r_rr_mode) begin
        w_nxt_rr_ptr = r_sel + CH_W'(1);
      end
    end
  end

  assign in_ready   = (r_state == ST_IDLE);
  assign busy       = (r_state == ST_HOLD);
  assign out_data   = r_hold;
  assign out_valid  = r_out_valid;
  assign sel_o      = r_sel;
  assign drop_pulse = r_drop_pulse;
  assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_demux_sched.sv
// Directed self-checking bench for demux_sched.
module tb_demux_sched;
  import demux_pkg::*;

  localparam int unsigned W       = 1;
  localparam int unsigned TIMEOUT = 15;
  localparam int unsigned CNT_W   = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              mode;
  logic [CH_W-1:0]   sel_i;
  logic              in_valid;
  logic [W-1:0]      in_data;
  logic              in_ready;
  logic [W-1:0]      out_data;
  logic [NUM_CH-1:0] out_valid;
  logic [NUM_CH-1:0] out_ready;
  logic [CH_W-1:0]   sel_o;
  logic              busy;
  logic              drop_pulse;
  logic [CNT_W-1:0]  drop_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  demux_sched #(.W(W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .sel_i      (sel_i),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sel_o      (sel_o),
    .busy       (busy),
    .drop_pulse (drop_pulse),
    .drop_cnt   (drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [CH_W-1:0]   rr_exp [5];
  logic [NUM_CH-1:0] oh_exp [5];

  initial begin
    rr_exp = '{CH_A, CH_B, CH_C, CH_D, CH_A};
    oh_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    rst_n     = 1'b0;
    mode      = 1'b0;
    sel_i     = CH_A;
    in_valid  = 1'b1;
    in_data   = 1'b1;
    out_ready = 4'b0000;
    @(negedge clk);
    step();
    step();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    chk("rst_in_ready",  32'(in_ready),   32'd1);
    chk("rst_out_valid", 32'(out_valid),  32'h0);
    chk("rst_sel_o",     32'(sel_o),      32'h0);
    chk("rst_drop_cnt",  32'(drop_cnt),   32'h0);
    chk("rst_out_data",  32'(out_data),   32'h0);
    chk("rst_busy",      32'(busy),       32'h0);

    // Explicit select to channel C
    mode      = 1'b0;
    sel_i     = CH_C;
    in_data   = 1'b1;
    in_valid  = 1'b1;
    out_ready = 4'b1111;
    step();
    in_valid = 1'b0;
    chk("exp_out_valid", 32'(out_valid), 32'h4);
    chk("exp_sel_o",     32'(sel_o),     32'h2);
    chk("exp_out_data",  32'(out_data),  32'h1);
    chk("exp_busy",      32'(busy),      32'h1);
    chk("exp_in_ready",  32'(in_ready),  32'h0);
    step();
    chk("exp_idle_valid", 32'(out_valid), 32'h0);
    chk("exp_idle_ready", 32'(in_ready),  32'h1);
    chk("exp_sel_hold",   32'(sel_o),     32'h2);
    chk("exp_data_hold",  32'(out_data),  32'h1);

    // Round-robin, back-to-back words at one per two cycles
    mode     = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_data = W'(k & 1);
      step();
      chk("rr_sel_o",     32'(sel_o),     32'(rr_exp[k]));
      chk("rr_out_valid", 32'(out_valid), 32'(oh_exp[k]));
      chk("rr_out_data",  32'(out_data),  32'(k & 1));
      step();
      chk("rr_in_ready",  32'(in_ready),  32'h1);
    end
    in_valid = 1'b0;

    // Timeout on channel D with only non-target channels ready
    mode      = 1'b0;
    sel_i     = CH_D;
    out_ready = 4'b0111;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      chk("to_out_valid", 32'(out_valid), 32'h8);
      chk("to_no_drop",   32'(drop_pulse), 32'h0);
      step();
    end
    chk("to_valid_clear", 32'(out_valid),  32'h0);
    chk("to_drop_pulse",  32'(drop_pulse), 32'h1);
    chk("to_drop_cnt",    32'(drop_cnt),   32'h1);
    chk("to_in_ready",    32'(in_ready),   32'h1);
    step();
    chk("to_pulse_once",  32'(drop_pulse), 32'h0);
    chk("to_cnt_hold",    32'(drop_cnt),   32'h1);

    // Ready arrives on the last permitted HOLD cycle
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    chk("bd_last_valid", 32'(out_valid), 32'h8);
    out_ready = 4'b1111;
    step();
    chk("bd_valid_clear", 32'(out_valid),  32'h0);
    chk("bd_no_drop",     32'(drop_pulse), 32'h0);
    chk("bd_cnt",         32'(drop_cnt),   32'h1);

    // Round-robin pointer survives explicit-mode traffic
    mode     = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("rr_resume_sel", 32'(sel_o), 32'(CH_B));
    step();

    // Select changes during HOLD are ignored; reset in HOLD drops silently
    mode      = 1'b0;
    sel_i     = CH_A;
    out_ready = 4'b0000;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    sel_i    = CH_D;
    mode     = 1'b1;
    step();
    chk("mid_sel_o",     32'(sel_o),     32'h0);
    chk("mid_out_valid", 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_valid", 32'(out_valid),  32'h0);
    chk("mid_rst_drop",  32'(drop_pulse), 32'h0);
    chk("mid_rst_ready", 32'(in_ready),   32'h1);
    chk("mid_rst_cnt",   32'(drop_cnt),   32'h0);
    for (int i = 0; i < TIMEOUT + 2; i++) begin
      step();
      chk("mid_quiet_drop",  32'(drop_pulse), 32'h0);
      chk("mid_quiet_valid", 32'(out_valid),  32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
